// File: rtl/manhattan_update_sequencer.sv
// Manhattan weight-update sequencer: walks the weight RAM, pairs each weight with a
// gradient, drives the updater for a fixed latency and writes the result back.
module manhattan_update_sequencer #(
    parameter int unsigned BIT_WIDTH      = 32,
    parameter int unsigned EXTRA_BITS     = 2,
    parameter int unsigned NUM_WEIGHTS    = 8,
    parameter int unsigned ADDR_WIDTH     = 3,
    parameter int unsigned UPDATE_LATENCY = 2,
    parameter logic [BIT_WIDTH+EXTRA_BITS-1:0] ETA_INIT = {2'b01, 32'h3A83126F}
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             eta_decay_en,
    input  logic [BIT_WIDTH+EXTRA_BITS-1:0]  grad_data,
    input  logic                             grad_valid,
    output logic                             grad_ready,
    output logic [ADDR_WIDTH-1:0]            wmem_raddr,
    input  logic [BIT_WIDTH+EXTRA_BITS-1:0]  wmem_rdata,
    output logic                             wmem_we,
    output logic [ADDR_WIDTH-1:0]            wmem_waddr,
    output logic [BIT_WIDTH+EXTRA_BITS-1:0]  wmem_wdata,
    output logic                             Manhattan_Enable,
    output logic [BIT_WIDTH+EXTRA_BITS-1:0]  Old_Weights,
    output logic [BIT_WIDTH+EXTRA_BITS-1:0]  eta,
    output logic [BIT_WIDTH+EXTRA_BITS-1:0]  Differentiated_Error,
    input  logic [BIT_WIDTH+EXTRA_BITS-1:0]  Updated_Weights,
    input  logic [BIT_WIDTH+EXTRA_BITS-1:0]  New_eta,
    output logic                             busy,
    output logic                             done,
    output logic                             update_err
);

    localparam int unsigned W     = BIT_WIDTH + EXTRA_BITS;
    localparam int unsigned CNT_W = (UPDATE_LATENCY > 1) ? $clog2(UPDATE_LATENCY) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WEIGHTS - 1);
    localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(UPDATE_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT_GRAD, S_UPDATE, S_WRITE, S_DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [CNT_W-1:0]      cnt;
    logic [W-1:0]          new_eta_q;
    logic                  result_bad;

    // Exception tags 10 (inf) and 11 (NaN) both have the top tag bit set.
    assign result_bad = Updated_Weights[W-1];

    // Pass sequencer: state, address walk, updater handshake and write-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= S_IDLE;
            addr                 <= '0;
            cnt                  <= '0;
            new_eta_q            <= '0;
            grad_ready           <= 1'b0;
            wmem_raddr           <= '0;
            wmem_we              <= 1'b0;
            wmem_waddr           <= '0;
            wmem_wdata           <= '0;
            Manhattan_Enable     <= 1'b0;
            Old_Weights          <= '0;
            eta                  <= ETA_INIT;
            Differentiated_Error <= '0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            update_err           <= 1'b0;
        end else begin
            done    <= 1'b0;
            wmem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr       <= '0;
                        wmem_raddr <= '0;
                        busy       <= 1'b1;
                        update_err <= 1'b0;
                        state      <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    grad_ready <= 1'b1;
                    state      <= S_WAIT_GRAD;
                end
                S_WAIT_GRAD: begin
                    if (grad_valid && grad_ready) begin
                        grad_ready           <= 1'b0;
                        Old_Weights          <= wmem_rdata;
                        Differentiated_Error <= grad_data;
                        Manhattan_Enable     <= 1'b1;
                        cnt                  <= '0;
                        state                <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    if (cnt == LAST_CNT) begin
                        Manhattan_Enable <= 1'b0;
                        wmem_waddr       <= addr;
                        wmem_wdata       <= Updated_Weights;
                        wmem_we          <= ~result_bad;
                        if (result_bad) begin
                            update_err <= 1'b1;
                        end
                        if (addr == LAST_ADDR) begin
                            new_eta_q <= New_eta;
                        end
                        state <= S_WRITE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WRITE: begin
                    if (addr == LAST_ADDR) begin
                        state <= S_DONE;
                    end else begin
                        addr       <= addr + ADDR_WIDTH'(1);
                        wmem_raddr <= addr + ADDR_WIDTH'(1);
                        state      <= S_FETCH;
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    if (eta_decay_en) begin
                        eta <= new_eta_q;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_manhattan_update_sequencer.sv
// Bench for manhattan_update_sequencer: RAM and updater models, write scoreboard,
// table of pass scenarios plus reset corner cases.
module tb_manhattan_update_sequencer;

    localparam int unsigned BW = 32;
    localparam int unsigned EB = 2;
    localparam int unsigned W  = BW + EB;
    localparam int unsigned N  = 2;
    localparam int unsigned AW = 1;
    localparam int unsigned L  = 2;
    localparam logic [W-1:0] ETA0    = {2'b01, 32'h3A83126F};
    localparam logic [W-1:0] ETA1    = {2'b01, 32'h38D1B717};
    localparam logic [W-1:0] WEIGHT  = {2'b01, 32'h3E6147AE};
    localparam logic [W-1:0] GRAD    = {2'b01, 32'hBF7D70A4};
    localparam logic [W-1:0] RESULT  = {2'b01, 32'h3E604189};
    localparam logic [W-1:0] BADRES  = {2'b11, 32'h3E604189};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          eta_decay_en = 1'b0;
    logic [W-1:0]  grad_data;
    logic          grad_valid = 1'b1;
    logic          grad_ready;
    logic [AW-1:0] wmem_raddr;
    logic [W-1:0]  wmem_rdata = '0;
    logic          wmem_we;
    logic [AW-1:0] wmem_waddr;
    logic [W-1:0]  wmem_wdata;
    logic          Manhattan_Enable;
    logic [W-1:0]  Old_Weights;
    logic [W-1:0]  eta;
    logic [W-1:0]  Differentiated_Error;
    logic [W-1:0]  Updated_Weights;
    logic [W-1:0]  New_eta;
    logic          busy;
    logic          done;
    logic          update_err;

    manhattan_update_sequencer #(
        .BIT_WIDTH(BW), .EXTRA_BITS(EB), .NUM_WEIGHTS(N), .ADDR_WIDTH(AW),
        .UPDATE_LATENCY(L), .ETA_INIT(ETA0)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .eta_decay_en(eta_decay_en),
        .grad_data(grad_data), .grad_valid(grad_valid), .grad_ready(grad_ready),
        .wmem_raddr(wmem_raddr), .wmem_rdata(wmem_rdata), .wmem_we(wmem_we),
        .wmem_waddr(wmem_waddr), .wmem_wdata(wmem_wdata),
        .Manhattan_Enable(Manhattan_Enable), .Old_Weights(Old_Weights), .eta(eta),
        .Differentiated_Error(Differentiated_Error), .Updated_Weights(Updated_Weights),
        .New_eta(New_eta), .busy(busy), .done(done), .update_err(update_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } wr_t;

    typedef struct {
        int           gap;
        bit           decay;
        bit           bad;
        int           exp_cycles;
        logic [W-1:0] exp_eta;
        bit           exp_err;
    } vec_t;

    wr_t          sb[$];
    logic [W-1:0] ram [N];
    int           tests = 0;
    int           fails = 0;
    int           idx = -1;
    int           gap_left = 0;
    bit           bad_mode = 1'b0;
    logic         prev_en = 1'b0;
    logic [W-1:0] cur_eta = ETA0;

    assign grad_data       = GRAD;
    assign New_eta         = ETA1;
    assign Updated_Weights = (bad_mode && idx == 1) ? BADRES : RESULT;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Synchronous-read weight RAM model.
    always @(posedge clk) begin
        if (wmem_we) ram[wmem_waddr] <= wmem_wdata;
        wmem_rdata <= ram[wmem_raddr];
    end

    // Monitor (scoreboard, operand checks) and gradient source with backpressure gaps.
    always @(negedge clk) begin
        if (!rst) begin
            if (Manhattan_Enable && !prev_en) begin
                idx++;
                check("old_weight", 64'(Old_Weights), 64'(ram[idx]));
                check("diff_err", 64'(Differentiated_Error), 64'(GRAD));
                check("eta_operand", 64'(eta), 64'(cur_eta));
            end
            if (grad_ready && !grad_valid) begin
                check("gap_enable", 64'(Manhattan_Enable), 64'(0));
                check("gap_we", 64'(wmem_we), 64'(0));
            end
            if (wmem_we) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", 64'(1), 64'(0));
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    check("waddr", 64'(wmem_waddr), 64'(e.addr));
                    check("wdata", 64'(wmem_wdata), 64'(e.data));
                end
            end
        end
        prev_en = Manhattan_Enable;
        if (grad_ready && gap_left > 0) begin
            grad_valid = 1'b0;
            gap_left--;
        end else begin
            grad_valid = 1'b1;
        end
    end

    task automatic run_pass(input vec_t v);
        int cyc;
        bit seen;
        gap_left     = v.gap;
        bad_mode     = v.bad;
        eta_decay_en = v.decay;
        idx          = -1;
        for (int a = 0; a < int'(N); a++) begin
            if (!(v.bad && a == 1)) sb.push_back('{AW'(a), RESULT});
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'(1));
        check("err_cleared", 64'(update_err), 64'(0));
        seen = 1'b0;
        cyc  = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (c == 2) start = 1'b1;
            if (c == 3) start = 1'b0;
            if (done) begin
                cyc  = c;
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("done_timeout", 64'(0), 64'(1));
        check("done_cycle", 64'(cyc), 64'(v.exp_cycles));
        check("busy_at_done", 64'(busy), 64'(0));
        check("eta_after", 64'(eta), 64'(v.exp_eta));
        check("update_err", 64'(update_err), 64'(v.exp_err));
        check("sb_empty", 64'(sb.size()), 64'(0));
        cur_eta = v.exp_eta;
        @(posedge clk);
        #1;
        check("done_pulse_1cyc", 64'(done), 64'(0));
        sb.delete();
    endtask

    initial begin
        vec_t vecs[5];
        bit   seen;
        vecs[0] = '{gap: 0, decay: 1'b0, bad: 1'b0, exp_cycles: 11, exp_eta: ETA0, exp_err: 1'b0};
        vecs[1] = '{gap: 5, decay: 1'b0, bad: 1'b0, exp_cycles: 16, exp_eta: ETA0, exp_err: 1'b0};
        vecs[2] = '{gap: 0, decay: 1'b1, bad: 1'b0, exp_cycles: 11, exp_eta: ETA1, exp_err: 1'b0};
        vecs[3] = '{gap: 0, decay: 1'b0, bad: 1'b1, exp_cycles: 11, exp_eta: ETA1, exp_err: 1'b1};
        vecs[4] = '{gap: 0, decay: 1'b0, bad: 1'b0, exp_cycles: 11, exp_eta: ETA1, exp_err: 1'b0};
        for (int a = 0; a < int'(N); a++) ram[a] = WEIGHT;

        // Reset, then re-assert asynchronously mid-cycle.
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_ready", 64'(grad_ready), 64'(0));
        check("rst_enable", 64'(Manhattan_Enable), 64'(0));
        check("rst_we", 64'(wmem_we), 64'(0));
        check("rst_raddr", 64'(wmem_raddr), 64'(0));
        check("rst_old", 64'(Old_Weights), 64'(0));
        check("rst_eta", 64'(eta), 64'(ETA0));
        check("rst_err", 64'(update_err), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_pass(vecs[i]);

        // Reset while the updater is enabled, then a clean pass from addr0.
        idx      = -1;
        bad_mode = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen  = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (Manhattan_Enable) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!seen) check("enable_timeout", 64'(0), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        check("midrst_enable", 64'(Manhattan_Enable), 64'(0));
        check("midrst_we", 64'(wmem_we), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_eta", 64'(eta), 64'(ETA0));
        check("midrst_writes", 64'(sb.size()), 64'(0));
        @(negedge clk);
        rst     = 1'b0;
        cur_eta = ETA0;
        run_pass('{gap: 0, decay: 1'b0, bad: 1'b0, exp_cycles: 11, exp_eta: ETA0, exp_err: 1'b0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
